// File: rtl/alu_mc_if.sv
// Handshake and data bundle between the execute stage and the multi-cycle ALU.
// The execute stage drives through "master"; the ALU itself connects through "slave".
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             flush_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] result_hi_o;
    logic             zero_o;

    modport master (
        output start_i, flush_i, ctrl_i, src1_i, src2_i,
        input  ready_o, done_o, result_o, result_hi_o, zero_o
    );

    modport slave (
        input  start_i, flush_i, ctrl_i, src1_i, src2_i,
        output ready_o, done_o, result_o, result_hi_o, zero_o
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops plus a sequential signed shift-add multiplier.
// Define ALU_MC_DIV_EN to add an unsigned restoring divider on code 15 (DIVU).
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int CNT_W = 6
) (
    input  logic    clk_i,
    input  logic    rst_n,
    alu_mc_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [3:0] OP_SMUL = 4'd13;
`ifdef ALU_MC_DIV_EN
    localparam logic [1:0] S_DIV   = 2'd2;
    localparam logic [3:0] OP_DIVU = 4'd15;
`endif

    logic [1:0]         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               done_reg;
    logic               zero_reg;
    logic               neg_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   result_hi_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic [WIDTH-1:0]   src1;
    logic [WIDTH-1:0]   src2;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [SHW-1:0]     sh_fixed;
    logic [SHW-1:0]     sh_var;
    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_final;

    assign src1      = bus.src1_i;
    assign src2      = bus.src2_i;
    assign sh_fixed  = src1[SHW+5:6];
    assign sh_var    = src1[SHW-1:0];
    assign accept    = (state_reg == S_IDLE) && bus.start_i && !bus.flush_i;
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
    assign mag1      = src1[WIDTH-1] ? -src1 : src1;
    assign mag2      = src2[WIDTH-1] ? -src2 : src2;

    always_comb begin
        alu_res = '0;
        case (bus.ctrl_i)
            4'd0:             alu_res = src1 & src2;
            4'd1:             alu_res = src1 | src2;
            4'd2, 4'd3, 4'd4: alu_res = src1 + src2;
            4'd5:             alu_res = src1 - src2;
            4'd6:             alu_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
            4'd11:            alu_res = {{(WIDTH-1){1'b0}}, src1 < src2};
            4'd7:             alu_res = {{(WIDTH-1){1'b0}}, src1[WIDTH-1] | (src1 == '0)};
            4'd14:            alu_res = {{(WIDTH-1){1'b0}}, !src1[WIDTH-1] && (src1 != '0)};
            4'd8:             alu_res = $signed(src2) >>> sh_fixed;
            4'd9:             alu_res = $signed(src2) >>> sh_var;
            4'd12:            alu_res = src2 << sh_fixed;
            4'd10:            alu_res = {src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:          alu_res = '0;
        endcase
    end

    // {hi_reg, lo_reg} is the partial product; lo_reg shifts out the multiplier LSB first.
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_prod  = {mul_sum, lo_reg[WIDTH-1:1]};
    assign mul_final = neg_reg ? -mul_prod : mul_prod;

`ifdef ALU_MC_DIV_EN
    // hi_reg holds the partial remainder; lo_reg shifts dividend out and quotient in.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_reg});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
    assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_quo   = {lo_reg[WIDTH-2:0], div_ge};
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            done_reg      <= 1'b0;
            zero_reg      <= 1'b0;
            neg_reg       <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            opnd_reg      <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.ctrl_i == OP_SMUL) begin
                            state_reg <= S_MUL;
                            cnt_reg   <= '0;
                            opnd_reg  <= mag1;
                            lo_reg    <= mag2;
                            hi_reg    <= '0;
                            neg_reg   <= src1[WIDTH-1] ^ src2[WIDTH-1];
                        end
`ifdef ALU_MC_DIV_EN
                        else if (bus.ctrl_i == OP_DIVU) begin
                            state_reg <= S_DIV;
                            cnt_reg   <= '0;
                            opnd_reg  <= src2;
                            lo_reg    <= src1;
                            hi_reg    <= '0;
                        end
`endif
                        else begin
                            result_reg    <= alu_res;
                            result_hi_reg <= '0;
                            zero_reg      <= (alu_res == '0);
                            done_reg      <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.flush_i) begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        hi_reg  <= mul_prod[2*WIDTH-1:WIDTH];
                        lo_reg  <= mul_prod[WIDTH-1:0];
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_iter) begin
                            state_reg     <= S_IDLE;
                            cnt_reg       <= '0;
                            done_reg      <= 1'b1;
                            result_reg    <= mul_final[WIDTH-1:0];
                            result_hi_reg <= mul_final[2*WIDTH-1:WIDTH];
                            zero_reg      <= (mul_final[WIDTH-1:0] == '0);
                        end
                    end
                end
`ifdef ALU_MC_DIV_EN
                S_DIV: begin
                    if (bus.flush_i) begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        hi_reg  <= div_rem;
                        lo_reg  <= div_quo;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_iter) begin
                            state_reg     <= S_IDLE;
                            cnt_reg       <= '0;
                            done_reg      <= 1'b1;
                            result_reg    <= div_quo;
                            result_hi_reg <= div_rem;
                            zero_reg      <= (div_quo == '0);
                        end
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o     = (state_reg == S_IDLE);
    assign bus.done_o      = done_reg;
    assign bus.result_o    = result_reg;
    assign bus.result_hi_o = result_hi_reg;
    assign bus.zero_o      = zero_reg;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver queues model results on accept, and a monitor
// pops and compares them whenever done_o is seen.
module tb_alu_mc;
    localparam int W        = 32;
    localparam int MULT_LAT = W + 1;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         zero;
        int           acc;
        int           lat;
    } exp_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    int     cyc    = 0;
    int     n_chk  = 0;
    int     n_pass = 0;
    exp_t   sb_q[$];
    logic [W-1:0] last_lo   = '0;
    logic [W-1:0] last_hi   = '0;
    logic         last_zero = 1'b0;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W), .SHW(5), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model written from the operation rules with integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        int     sa;
        int     sb;
        int     sh;
        longint p;
        longint v;
        longint d;
        sa = a;
        sb = b;
        e.op = op; e.lo = '0; e.hi = '0; e.acc = 0; e.lat = 1;
        case (op)
            4'd0:             e.lo = a & b;
            4'd1:             e.lo = a | b;
            4'd2, 4'd3, 4'd4: e.lo = a + b;
            4'd5:             e.lo = a - b;
            4'd6:             e.lo = W'(sa < sb);
            4'd11:            e.lo = W'(a < b);
            4'd7:             e.lo = W'(sa <= 0);
            4'd14:            e.lo = W'(sa > 0);
            4'd8, 4'd9: begin
                sh = (op == 4'd8) ? int'(a[10:6]) : int'(a[4:0]);
                v  = sb;
                d  = longint'(1) << sh;
                p  = v / d;
                if (v < 0 && (v % d) != 0) p = p - 1;
                e.lo = p[W-1:0];
            end
            4'd12: begin
                sh   = int'(a[10:6]);
                p    = longint'(b) * (longint'(1) << sh);
                e.lo = p[W-1:0];
            end
            4'd10: begin
                p    = longint'(b) * 65536;
                e.lo = p[W-1:0];
            end
            4'd13: begin
                p     = longint'(sa) * longint'(sb);
                e.lo  = p[W-1:0];
                e.hi  = p[2*W-1:W];
                e.lat = MULT_LAT;
            end
`ifdef ALU_MC_DIV_EN
            4'd15: begin
                if (b == '0) begin
                    e.lo = '1;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
                e.lat = MULT_LAT;
            end
`endif
            default: e.lo = '0;
        endcase
        e.zero = (e.lo == '0);
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!bus.ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.ready_o, 1);
        bus.start_i = 1'b1;
        bus.flush_i = 1'b0;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        e     = model(op, a, b);
        e.acc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", W'(sb_q.size()), 0);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom % 4)
            0:       return W'($urandom_range(0, 20));
            1:       return W'(-int'($urandom_range(0, 20)));
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.done_o) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                $display("op %0d: result 0x%08h hi 0x%08h zero %0b latency %0d",
                         e.op, bus.result_o, bus.result_hi_o, bus.zero_o, cyc - e.acc);
                check("result", bus.result_o, e.lo);
                check("result_hi", bus.result_hi_o, e.hi);
                check("zero", bus.zero_o, e.zero);
                check("latency", W'(cyc - e.acc), W'(e.lat));
                last_lo   = e.lo;
                last_hi   = e.hi;
                last_zero = e.zero;
            end
        end
    end

    initial begin
        logic [3:0] op;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ctrl_i  = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready_o, 1);
        check("rst_done", bus.done_o, 0);
        check("rst_result", bus.result_o, 0);
        check("rst_result_hi", bus.result_hi_o, 0);
        check("rst_zero", bus.zero_o, 0);
        rst_n = 1'b1;

        // Directed cases; SLT is accepted in the same cycle the SMUL reports done.
        issue(4'd13, 32'hFFFF_FFFD, 32'd7);
        issue(4'd6,  32'd1, 32'hFFFF_FFFF);
        issue(4'd11, 32'd1, 32'hFFFF_FFFF);
        issue(4'd5,  32'd4, 32'd4);
        issue(4'd8,  32'h100, 32'h8000_0000);
        issue(4'd12, 32'h100, 32'h8000_0000);
        issue(4'd9,  32'd4, 32'h8000_0000);
        issue(4'd10, 32'd0, 32'h0000_1234);
        issue(4'd15, 32'd100, 32'd7);
        issue(4'd15, 32'd9, 32'd0);
        issue(4'd7,  32'd0, 32'd0);
        issue(4'd14, 32'h8000_0000, 32'd0);
        idle();
        drain();

        // start_i held through the busy cycles must not be accepted.
        issue(4'd13, 32'h8000_0000, 32'h8000_0000);
        @(negedge clk);
        bus.ctrl_i = 4'd4;
        repeat (W - 1) @(negedge clk);
        bus.start_i = 1'b0;
        drain();

        // Flush mid-multiply at cycle 10 after accept.
        issue(4'd4, 32'd1, 32'd2);
        idle();
        drain();
        issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_ready", bus.ready_o, 1);
        check("flush_done", bus.done_o, 0);
        check("flush_hold_result", bus.result_o, last_lo);
        check("flush_hold_hi", bus.result_hi_o, last_hi);
        check("flush_hold_zero", bus.zero_o, last_zero);
        repeat (40) @(negedge clk);

        // flush_i in IDLE blocks a simultaneous start_i.
        bus.start_i = 1'b1;
        bus.ctrl_i  = 4'd4;
        bus.src1_i  = 32'd3;
        bus.src2_i  = 32'd3;
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("idle_flush_done", bus.done_o, 0);
        check("idle_flush_result", bus.result_o, last_lo);
        repeat (3) @(negedge clk);

        // Reset in the middle of a multiply.
        issue(4'd13, 32'hFFFF_FFF0, 32'h0000_7777);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        last_lo = '0; last_hi = '0; last_zero = 1'b0;
        #1;
        check("midrst_ready", bus.ready_o, 1);
        check("midrst_done", bus.done_o, 0);
        check("midrst_result", bus.result_o, 0);
        check("midrst_result_hi", bus.result_hi_o, 0);
        check("midrst_zero", bus.zero_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd4, 32'd5, 32'd7);
        idle();
        drain();

        // Randomized traffic with occasional idle gaps.
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, rnd_operand(), rnd_operand());
            if ($urandom % 4 == 0) idle();
        end
        idle();
        drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the pipelined CPU's execute stage. It keeps the existing 4-bit ALU control encoding and replaces the combinational multiply with a sequential signed shift-add multiplier that returns a full double-width product. Optionally it adds an unsigned iterative divider. A start/ready/done handshake lets the hazard unit stall the pipeline while a multi-cycle op is in flight.

## Interface
- WIDTH, 32: datapath width; even, ≥ 16.
- SHW, 5: shift-amount width; must equal log2(WIDTH).
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request; accepted only when ready_o=1.
- flush_i  in  1  synchronous cancel of an in-flight op.
- ctrl_i  in  4  operation code, sampled on accept.
- src1_i  in  WIDTH  operand 1, sampled on accept.
- src2_i  in  WIDTH  operand 2, sampled on accept.
- ready_o  out  1  unit is idle and can accept.
- done_o  out  1  one-cycle pulse; results are valid.
- result_o  out  WIDTH  result, or low product, or quotient.
- result_hi_o  out  WIDTH  high product or remainder; 0 for other ops.
- zero_o  out  1  (result_o == 0), updated with done_o.

## Operation
- Codes:
  - 0 AND, 1 OR.
  - 2 LW, 3 SW, 4 ADDU: all add, modulo 2^WIDTH, no overflow trap.
  - 5 SUBU: src1−src2.
  - 6 SLT: signed src1<src2 → 1, else 0.
  - 11 SLTU: unsigned src1<src2 → 1, else 0.
  - 7 BLEZ: 1 if signed src1 ≤ 0.
  - 14 BGTZ: 1 if signed src1 > 0.
  - 8 SRA: src2 arithmetic-shifted right by src1[SHW+5:6].
  - 9 SRAV: src2 arithmetic-shifted right by src1[SHW-1:0].
  - 12 SLL: src2 shifted left by src1[SHW+5:6].
  - 10 LUI: {src2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 13 SMUL: signed src1×src2; 2·WIDTH-bit product, {result_hi_o, result_o}.
  - 15: DIVU when the divider is compiled in, else undefined.
- Single-cycle ops and undefined codes: result_hi_o=0. Undefined codes give result_o=0.
- SMUL: operand magnitudes are multiplied unsigned, one bit per cycle, LSB first. The product is negated at the end if the operand signs differ.
- FSM states: IDLE, MUL, DIV (DIV only with the macro).
  - IDLE → MUL on accepting SMUL; IDLE → DIV on accepting DIVU; otherwise stay in IDLE.
  - MUL/DIV → IDLE after WIDTH iterations, pulsing done_o.
  - MUL/DIV → IDLE on flush_i, with no done_o.
- ready_o=1 only in IDLE.
- start_i while ready_o=0 is ignored; it is not queued.
- flush_i in IDLE blocks acceptance in that cycle. flush_i wins over a simultaneous start_i.
- result_o, result_hi_o and zero_o hold their values between done_o pulses. A flush leaves them unchanged.

## Timing
- Reset values: ready_o=1, done_o=0, result_o=0, result_hi_o=0, zero_o=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. No done_o is produced.
- Single-cycle op accepted in cycle N: outputs are registered at the end of N. done_o=1 and ready_o=1 in cycle N+1.
- Back-to-back single-cycle ops give one result per cycle.
- SMUL/DIVU accepted in cycle N:
  - ready_o=0 in cycles N+1 .. N+WIDTH.
  - done_o=1 and ready_o=1 in cycle N+WIDTH+1.
  - Latency is WIDTH+1 cycles.
- A new op may be accepted in the same cycle done_o is high.
- The counter counts 0..WIDTH-1. The last iteration and the sign fix-up complete on the same edge.
- flush_i in MUL/DIV: IDLE in the next cycle, ready_o=1.

## Configuration
- ALU_MC_DIV_EN defined:
  - Code 15 is DIVU: unsigned restoring division, one quotient bit per cycle, same latency as SMUL.
  - Quotient goes to result_o, remainder to result_hi_o.
  - Divide by zero: result_o all ones, result_hi_o=src1. Completes at normal latency.
- ALU_MC_DIV_EN undefined:
  - No divider logic and no DIV state.
  - Code 15 is undefined: single-cycle, result_o=0, zero_o=1.

## Test plan
- Reset mid-SMUL, then release → ready_o=1, done_o=0, all results 0. The next ADDU 5+7 gives result_o=12, one cycle after accept.
- SMUL src1=0xFFFFFFFD (−3), src2=7, WIDTH=32 → done_o exactly 33 cycles after accept; result_o=0xFFFFFFEB, result_hi_o=0xFFFFFFFF, zero_o=0.
- Back-to-back SLT then SLTU with src1=1, src2=0xFFFFFFFF → results 0 then 1 on consecutive cycles. SUBU 4−4 → result_o=0, zero_o=1.
- SRA src2=0x80000000, src1=0x100 → 0xF8000000. SLL same operands → 0. SRAV src1=4 → 0xF8000000. LUI src2=0x1234 → 0x12340000.
- SMUL accepted, flush_i at cycle 10 → no done_o, ready_o=1 next cycle, previous result held. start_i during busy cycles is ignored.
- With ALU_MC_DIV_EN: DIVU 100/7 → result_o=14, result_hi_o=2. DIVU 9/0 → result_o=0xFFFFFFFF, result_hi_o=9. Without the macro: code 15 → result_o=0, done_o one cycle after accept.
